// File: rtl/mlp_pkg.sv
// Shared fixed-point helpers, FSM state type and sizing function for the MLP trainer.
// Define MLP_SAT_EN to make every multiply and add/sub saturate instead of wrap.
package mlp_pkg;

  localparam int unsigned FX_MAXW = 64;

  typedef logic signed [FX_MAXW-1:0]   fx_wide_t;
  typedef logic signed [2*FX_MAXW-1:0] fx_ext_t;

  typedef enum logic [2:0] {
    StIdle,
    StFwdHid,
    StFwdOut,
    StBack,
    StUpd,
    StResp
  } state_e;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic fx_wide_t fx_one(input int unsigned frac);
    return fx_wide_t'(1) <<< frac;
  endfunction

  function automatic fx_wide_t fx_half(input int unsigned frac);
    return fx_wide_t'(1) <<< (frac - 1);
  endfunction

  // Reduce an exact result to a w-bit signed value, sign-extended to fx_wide_t.
  function automatic fx_wide_t fx_fit(input fx_ext_t v, input int unsigned w);
`ifdef MLP_SAT_EN
    fx_ext_t hi;
    fx_ext_t lo;
    hi = (fx_ext_t'(1) <<< (w - 1)) - fx_ext_t'(1);
    lo = -(fx_ext_t'(1) <<< (w - 1));
    if (v > hi) return fx_wide_t'(hi);
    if (v < lo) return fx_wide_t'(lo);
    return fx_wide_t'(v);
`else
    fx_ext_t t;
    t = (v <<< (2 * FX_MAXW - w)) >>> (2 * FX_MAXW - w);
    return fx_wide_t'(t);
`endif
  endfunction

  function automatic fx_wide_t fx_mul(input fx_wide_t a, input fx_wide_t b,
                                      input int unsigned w, input int unsigned frac);
    fx_ext_t p;
    p = fx_ext_t'(a) * fx_ext_t'(b);
    return fx_fit(p >>> frac, w);
  endfunction

  function automatic fx_wide_t fx_add(input fx_wide_t a, input fx_wide_t b,
                                      input int unsigned w);
    return fx_fit(fx_ext_t'(a) + fx_ext_t'(b), w);
  endfunction

  function automatic fx_wide_t fx_sub(input fx_wide_t a, input fx_wide_t b,
                                      input int unsigned w);
    return fx_fit(fx_ext_t'(a) - fx_ext_t'(b), w);
  endfunction

endpackage

// File: rtl/mlp_hard_sigmoid.sv
// Combinational hard sigmoid: h = clamp((s >>> 2) + 0.5, 0, 1.0) in Q(W-FRAC).FRAC.
module mlp_hard_sigmoid import mlp_pkg::*; #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 16
) (
  input  logic [W-1:0] s,
  output logic [W-1:0] h
);

  fx_wide_t s_w;
  fx_wide_t t;
  fx_wide_t one;

  // (s >>> 2) + 0.5 lies well inside the W-bit range, so no wrap handling is needed.
  always_comb begin
    s_w = fx_wide_t'(signed'(s));
    one = fx_one(FRAC);
    t   = (s_w >>> 2) + fx_half(FRAC);
    if (t < 0) begin
      t = '0;
    end else if (t > one) begin
      t = one;
    end
    h = t[W-1:0];
  end

endmodule

// File: rtl/mlp_trainer_seq.sv
// Time-multiplexed N_IN-N_HID-1 MLP trainer with one shared MAC and a six-state FSM.
// Define MLP_SAT_EN for saturating arithmetic; cycle timing is the same in both builds.
module mlp_trainer_seq import mlp_pkg::*; #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_HID  = 4,
  parameter int unsigned W      = 32,
  parameter int unsigned FRAC   = 16,
  parameter logic [W-1:0] LR     = 32'h0000_4000,
  parameter logic [W-1:0] INIT_W = 32'h0000_3800
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [N_IN*W-1:0]                      s_x,
  input  logic [W-1:0]                           s_target,
  input  logic                                   s_train,
  output logic                                   r_valid,
  input  logic                                   r_ready,
  output logic [W-1:0]                           r_y,
  output logic [W-1:0]                           r_err,
  output logic [31:0]                            iter_count,
  output logic                                   busy,
  input  logic [addr_w(N_HID*N_IN+N_HID)-1:0]    wt_rd_addr,
  output logic [W-1:0]                           wt_rd_data
);

  localparam int unsigned N_WH = N_HID * N_IN;
  localparam int unsigned N_WT = N_WH + N_HID;
  localparam int unsigned AW   = addr_w(N_WT);
  localparam int unsigned JW   = addr_w(N_HID);
  localparam int unsigned IW   = addr_w(N_IN);
  localparam logic [W-1:0] ONE_W = W'(fx_one(FRAC));

  function automatic logic [W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    fx_wide_t r;
    r = fx_mul(fx_wide_t'(signed'(a)), fx_wide_t'(signed'(b)), W, FRAC);
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] add(input logic [W-1:0] a, input logic [W-1:0] b);
    fx_wide_t r;
    r = fx_add(fx_wide_t'(signed'(a)), fx_wide_t'(signed'(b)), W);
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub(input logic [W-1:0] a, input logic [W-1:0] b);
    fx_wide_t r;
    r = fx_sub(fx_wide_t'(signed'(a)), fx_wide_t'(signed'(b)), W);
    return r[W-1:0];
  endfunction

  state_e state_q, state_d;

  logic [W-1:0]  wt_q [N_WT];
  logic [W-1:0]  x_q  [N_IN];
  logic [W-1:0]  h_q  [N_HID];
  logic [W-1:0]  dh_q [N_HID];
  logic [W-1:0]  target_q, acc_q, y_q;
  logic          train_q, upd_o_q;
  logic [IW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [31:0]   iter_q;

  logic          i_last, j_last;
  logic [JW-1:0] j_next;
  logic [AW-1:0] wh_idx, wo_idx;
  logic [W-1:0]  d_o, dh_new, act_h;
  logic [W-1:0]  mac_a, mac_b, mac_c, mac_s;

  assign i_last = (i_q == IW'(N_IN - 1));
  assign j_last = (j_q == JW'(N_HID - 1));
  assign j_next = j_last ? '0 : j_q + 1'b1;
  assign wh_idx = AW'(j_q * N_IN + i_q);
  assign wo_idx = AW'(N_WH + j_q);
  assign d_o    = sub(target_q, y_q);

  // d_h[j] = d_o * w_o[j] * h_j * (1 - h_j), evaluated left to right on pre-update w_o.
  assign dh_new = mul(mul(mul(d_o, wt_q[wo_idx]), h_q[j_q]), sub(ONE_W, h_q[j_q]));

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    case (state_q)
      StFwdHid: begin
        mac_a = x_q[i_q];
        mac_b = wt_q[wh_idx];
        mac_c = acc_q;
      end
      StFwdOut: begin
        mac_a = h_q[j_q];
        mac_b = wt_q[wo_idx];
        mac_c = y_q;
      end
      StUpd: begin
        if (upd_o_q) begin
          mac_a = mul(LR, d_o);
          mac_b = h_q[j_q];
          mac_c = wt_q[wo_idx];
        end else begin
          mac_a = mul(LR, dh_q[j_q]);
          mac_b = x_q[i_q];
          mac_c = wt_q[wh_idx];
        end
      end
      default: ;
    endcase
    mac_s = add(mac_c, mul(mac_a, mac_b));
  end

  mlp_hard_sigmoid #(
    .W    (W),
    .FRAC (FRAC)
  ) u_act (
    .s (mac_s),
    .h (act_h)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (s_valid) state_d = StFwdHid;
      StFwdHid: if (i_last && j_last) state_d = StFwdOut;
      StFwdOut: if (j_last) state_d = train_q ? StBack : StResp;
      StBack:   if (j_last) state_d = StUpd;
      StUpd:    if (upd_o_q && j_last) state_d = StResp;
      StResp:   if (r_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready = (state_q == StIdle);
    busy    = (state_q != StIdle);
    r_valid = (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_WT; k++) wt_q[k] <= INIT_W;
      for (int k = 0; k < N_IN; k++) x_q[k] <= '0;
      for (int k = 0; k < N_HID; k++) begin
        h_q[k]  <= '0;
        dh_q[k] <= '0;
      end
      target_q <= '0;
      train_q  <= 1'b0;
      acc_q    <= '0;
      y_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      upd_o_q  <= 1'b0;
      iter_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (s_valid) begin
            for (int k = 0; k < N_IN; k++) x_q[k] <= s_x[k*W +: W];
            target_q <= s_target;
            train_q  <= s_train;
            acc_q    <= '0;
            y_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            upd_o_q  <= 1'b0;
          end
        end
        StFwdHid: begin
          acc_q <= i_last ? '0 : mac_s;
          i_q   <= i_last ? '0 : i_q + 1'b1;
          if (i_last) begin
            h_q[j_q] <= act_h;
            j_q      <= j_next;
          end
        end
        StFwdOut: begin
          y_q <= mac_s;
          j_q <= j_next;
        end
        StBack: begin
          dh_q[j_q] <= dh_new;
          j_q       <= j_next;
        end
        StUpd: begin
          if (!upd_o_q) begin
            wt_q[wh_idx] <= mac_s;
            i_q          <= i_last ? '0 : i_q + 1'b1;
            if (i_last) begin
              j_q <= j_next;
              if (j_last) upd_o_q <= 1'b1;
            end
          end else begin
            wt_q[wo_idx] <= mac_s;
            j_q          <= j_next;
            if (j_last) iter_q <= iter_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r_y        = y_q;
  assign r_err      = d_o;
  assign iter_count = iter_q;
  assign wt_rd_data = (32'(wt_rd_addr) < N_WT) ? wt_q[wt_rd_addr] : '0;

endmodule

// File: tb/tb_mlp_trainer_seq.sv
// Randomised self-checking bench for mlp_trainer_seq against a behavioural MLP model.
module tb_mlp_trainer_seq;

  localparam logic [31:0] INIT = 32'h0000_3800;
  localparam logic [31:0] LRV  = 32'h0000_4000;
  localparam logic [31:0] ONE  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, s_train, r_valid, r_ready, busy;
  logic [63:0] s_x;
  logic [31:0] s_target, r_y, r_err, iter_count, wt_rd_data;
  logic [3:0]  wt_rd_addr;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_wh [4][2];
  logic [31:0] m_wo [4];
  logic [31:0] m_iter, exp_y, exp_err, last_y, last_err;

  always #5 clk = ~clk;

  mlp_trainer_seq dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_x        (s_x),
    .s_target   (s_target),
    .s_train    (s_train),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_y        (r_y),
    .r_err      (r_err),
    .iter_count (iter_count),
    .busy       (busy),
    .wt_rd_addr (wt_rd_addr),
    .wt_rd_data (wt_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: exact 64-bit integer maths, then wrap or clamp to 32 bits.
  function automatic longint sx(input logic [31:0] a);
    return longint'(signed'(a));
  endfunction

  function automatic logic [31:0] m_fit(input longint v);
    longint t;
    t = v;
`ifdef MLP_SAT_EN
    if (t > 64'sd2147483647) t = 64'sd2147483647;
    if (t < -64'sd2147483648) t = -64'sd2147483648;
`endif
    return t[31:0];
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    return m_fit((sx(a) * sx(b)) >>> 16);
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    return m_fit(sx(a) + sx(b));
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] a, input logic [31:0] b);
    return m_fit(sx(a) - sx(b));
  endfunction

  function automatic logic [31:0] m_act(input logic [31:0] s);
    longint t;
    t = (sx(s) >>> 2) + 64'sd32768;
    if (t < 0) t = 0;
    if (t > 64'sd65536) t = 64'sd65536;
    return t[31:0];
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < 4; j++) begin
      m_wo[j] = INIT;
      for (int i = 0; i < 2; i++) m_wh[j][i] = INIT;
    end
    m_iter = 0;
  endfunction

  function automatic void model_run(input logic [31:0] x0, input logic [31:0] x1,
                                    input logic [31:0] tgt, input logic trn);
    logic [31:0] x [2];
    logic [31:0] h [4];
    logic [31:0] dh [4];
    logic [31:0] s;
    x[0] = x0;
    x[1] = x1;
    exp_y = 0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int i = 0; i < 2; i++) s = m_add(s, m_mul(x[i], m_wh[j][i]));
      h[j] = m_act(s);
    end
    for (int j = 0; j < 4; j++) exp_y = m_add(exp_y, m_mul(h[j], m_wo[j]));
    exp_err = m_sub(tgt, exp_y);
    if (trn) begin
      for (int j = 0; j < 4; j++)
        dh[j] = m_mul(m_mul(m_mul(exp_err, m_wo[j]), h[j]), m_sub(ONE, h[j]));
      for (int j = 0; j < 4; j++)
        for (int i = 0; i < 2; i++)
          m_wh[j][i] = m_add(m_wh[j][i], m_mul(m_mul(LRV, dh[j]), x[i]));
      for (int j = 0; j < 4; j++) m_wo[j] = m_add(m_wo[j], m_mul(m_mul(LRV, exp_err), h[j]));
      m_iter = m_iter + 1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_weights(input string tag);
    logic [31:0] e;
    for (int a = 0; a < 16; a++) begin
      wt_rd_addr = 4'(a);
      #1;
      if (a < 8) e = m_wh[a/2][a%2];
      else if (a < 12) e = m_wo[a-8];
      else e = 0;
      check($sformatf("%s_w%0d", tag, a), wt_rd_data, e);
    end
  endtask

  task automatic send(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] tgt,
                      input logic trn);
    int n;
    n = 0;
    s_x      = {x1, x0};
    s_target = tgt;
    s_train  = trn;
    s_valid  = 1'b1;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    check("s_ready_wait", s_ready, 1);
    step();
    s_valid = 1'b0;
    model_run(x0, x1, tgt, trn);
  endtask

  task automatic collect(input int exp_lat, input int hold);
    int lat;
    lat = 1;
    while (!r_valid && lat < 200) begin
      step();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("r_y", r_y, exp_y);
    check("r_err", r_err, exp_err);
    last_y   = r_y;
    last_err = r_err;
    for (int k = 0; k < hold; k++) begin
      step();
      check("hold_valid", r_valid, 1);
      check("hold_y", r_y, exp_y);
      check("hold_err", r_err, exp_err);
      check("hold_s_ready", s_ready, 0);
    end
    r_ready = 1'b1;
    #1;
    check("resp_s_ready", s_ready, 0);
    step();
    r_ready = 1'b0;
    check("after_resp_s_ready", s_ready, 1);
    check("after_resp_valid", r_valid, 0);
    check("iter_count", iter_count, m_iter);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx0, rx1, rt;
    logic        rtr;
    rst = 1'b1; s_valid = 1'b0; r_ready = 1'b0; s_x = '0; s_target = '0; s_train = 1'b0;
    wt_rd_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    model_reset();
    check("rst_s_ready", s_ready, 1);
    check("rst_r_valid", r_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_iter", iter_count, 0);
    check("rst_r_y", r_y, 0);
    check("rst_r_err", r_err, 0);
    check_weights("rst");

    send(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);
    collect(13, 0);
    check("dir_inf_y", last_y, 32'h0000_8880);
    check("dir_inf_err", last_err, 32'hFFFF_7780);
    check_weights("inf");

    send(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    collect(29, 0);
    check("dir_trn_y", last_y, 32'h0000_8880);
    check("dir_trn_iter", iter_count, 1);
    for (int j = 0; j < 4; j++) begin
      wt_rd_addr = 4'(8 + j);
      #1;
      check($sformatf("wo%0d_decreased", j), $signed(wt_rd_data) < $signed(INIT), 1);
    end
    check_weights("trn");

    send(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);
    collect(13, 0);
    check("y_dropped", $signed(last_y) < $signed(32'h0000_8880), 1);

    // Backpressure with a second sample already offered during RESP.
    send(32'h0000_8000, 32'hFFFF_8000, 32'h0001_0000, 1'b1);
    s_x = {32'h0002_0000, 32'hFFFF_0000};
    s_target = 32'h0;
    s_train = 1'b0;
    s_valid = 1'b1;
    collect(29, 10);
    send(32'hFFFF_0000, 32'h0002_0000, 32'h0, 1'b0);
    collect(13, 0);
    check_weights("bp");

    for (int n = 0; n < 16; n++) begin
      rx0 = 32'($urandom_range(0, 262144)) - 32'd131072;
      rx1 = 32'($urandom_range(0, 262144)) - 32'd131072;
      rt  = 32'($urandom_range(0, 131072)) - 32'd65536;
      rtr = 1'($urandom_range(0, 1));
      send(rx0, rx1, rt, rtr);
      collect(rtr ? 29 : 13, n % 3);
      check_weights($sformatf("rnd%0d", n));
    end

    // Reset while the hidden-layer weight update is in progress.
    send(32'h0001_8000, 32'hFFFF_4000, 32'h0000_8000, 1'b1);
    repeat (19) step();
    check("upd_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("upd_rst_valid", r_valid, 0);
    check("upd_rst_iter", iter_count, 0);
    check("upd_rst_s_ready", s_ready, 1);
    check_weights("upd_rst");

    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 1'b0);
    collect(13, 0);
    check("big_x_y", last_y, 32'h0000_E000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
